// File: rtl/syn_fifo_pkg.sv
// Shared helpers for the syn_fifo_flex FIFO family: pointer sizing,
// read-mode encodings and parameter legality checks.
package syn_fifo_pkg;

   localparam int FIFO_MODE_REG  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit th_ok(input int depth,
                                input int afull,
                                input int aempty);
      bit pow2;
      pow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
      return pow2 &&
             (afull >= 1) && (afull <= depth) &&
             (aempty >= 0) && (aempty <= depth - 1);
   endfunction

endpackage

// File: rtl/syn_fifo_mem.sv
// Register-array storage for syn_fifo_flex: one synchronous write port,
// one asynchronous read port; contents are never reset.
module syn_fifo_mem #(
   parameter int P_DATA_W = 8,
   parameter int P_DEPTH  = 16,
   parameter int P_AW     = $clog2(P_DEPTH)
) (
   input  logic                clk,
   input  logic                i_we,
   input  logic [P_AW-1:0]     i_waddr,
   input  logic [P_DATA_W-1:0] i_wdata,
   input  logic [P_AW-1:0]     i_raddr,
   output logic [P_DATA_W-1:0] o_rdata
);

   logic [P_DATA_W-1:0] mem_q [P_DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/syn_fifo_flex.sv
// Single-clock FIFO with registered or FWFT read, count and almost flags.
// Define SYN_FIFO_FLEX_ERR_EN to add sticky o_ovf/o_udf error outputs.
module syn_fifo_flex
   import syn_fifo_pkg::*;
#(
   parameter int P_DATA_W    = 8,
   parameter int P_DEPTH     = 16,
   parameter int P_AFULL_TH  = 12,
   parameter int P_AEMPTY_TH = 2,
   parameter int P_FWFT      = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_flush,
   input  logic [P_DATA_W-1:0]          i_data,
   input  logic                         i_wr_en,
   input  logic                         i_rd_en,
   output logic                         o_full,
   output logic                         o_empty,
   output logic                         o_afull,
   output logic                         o_aempty,
   output logic [$clog2(P_DEPTH):0]     o_count,
`ifdef SYN_FIFO_FLEX_ERR_EN
   output logic                         o_ovf,
   output logic                         o_udf,
`endif
   output logic [P_DATA_W-1:0]          o_data
);

   localparam int PW = ptr_w(P_DEPTH);
   localparam int AW = PW - 1;

   if (!th_ok(P_DEPTH, P_AFULL_TH, P_AEMPTY_TH)) begin : g_bad_param
      $error("syn_fifo_flex: illegal depth or threshold parameters");
   end

   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]       count;
   logic                wr_acc, rd_acc;
   logic [P_DATA_W-1:0] rdata;

   // Flags come from registered pointers only, so accepts see pre-edge state.
   assign count    = wr_ptr_q - rd_ptr_q;
   assign o_count  = count;
   assign o_full   = (count == PW'(P_DEPTH));
   assign o_empty  = (count == '0);
   assign o_afull  = (count >= PW'(P_AFULL_TH));
   assign o_aempty = (count <= PW'(P_AEMPTY_TH));

   assign wr_acc = i_wr_en && !o_full  && !i_flush;
   assign rd_acc = i_rd_en && !o_empty && !i_flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   syn_fifo_mem #(
      .P_DATA_W (P_DATA_W),
      .P_DEPTH  (P_DEPTH),
      .P_AW     (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (wr_acc),
      .i_waddr (wr_ptr_q[AW-1:0]),
      .i_wdata (i_data),
      .i_raddr (rd_ptr_q[AW-1:0]),
      .o_rdata (rdata)
   );

   if (P_FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign o_data = rdata;
   end else begin : g_reg
      logic [P_DATA_W-1:0] data_q;
      // Holds across flush and refused reads; only a real pop reloads it.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_q <= '0;
         end else if (rd_acc) begin
            data_q <= rdata;
         end
      end
      assign o_data = data_q;
   end

`ifdef SYN_FIFO_FLEX_ERR_EN
   logic ovf_q, udf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else if (i_flush) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (i_wr_en && o_full)  ovf_q <= 1'b1;
         if (i_rd_en && o_empty) udf_q <= 1'b1;
      end
   end

   assign o_ovf = ovf_q;
   assign o_udf = udf_q;
`endif

endmodule

// File: tb/tb_syn_fifo_flex.sv
// Directed bench for syn_fifo_flex: one registered-read and one FWFT
// instance driven by the same stimulus, checked against hand-computed values.
module tb_syn_fifo_flex;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic [7:0] din;
   logic       wr;
   logic       rd;

   logic       full, empty, afull, aempty;
   logic [4:0] count;
   logic [7:0] dout;
   logic       full_f, empty_f, afull_f, aempty_f;
   logic [4:0] count_f;
   logic [7:0] dout_f;
`ifdef SYN_FIFO_FLEX_ERR_EN
   logic       ovf, udf, ovf_f, udf_f;
`endif

   int total = 0;
   int bad   = 0;

   syn_fifo_flex #(
      .P_DATA_W(8), .P_DEPTH(16), .P_AFULL_TH(12),
      .P_AEMPTY_TH(2), .P_FWFT(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_data(din),
      .i_wr_en(wr), .i_rd_en(rd), .o_full(full), .o_empty(empty),
      .o_afull(afull), .o_aempty(aempty), .o_count(count),
`ifdef SYN_FIFO_FLEX_ERR_EN
      .o_ovf(ovf), .o_udf(udf),
`endif
      .o_data(dout)
   );

   syn_fifo_flex #(
      .P_DATA_W(8), .P_DEPTH(16), .P_AFULL_TH(12),
      .P_AEMPTY_TH(2), .P_FWFT(1)
   ) dut_f (
      .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_data(din),
      .i_wr_en(wr), .i_rd_en(rd), .o_full(full_f), .o_empty(empty_f),
      .o_afull(afull_f), .o_aempty(aempty_f), .o_count(count_f),
`ifdef SYN_FIFO_FLEX_ERR_EN
      .o_ovf(ovf_f), .o_udf(udf_f),
`endif
      .o_data(dout_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       wr;
      bit       rd;
      bit       fl;
      bit [7:0] din;
      int       cnt;
      bit       full;
      bit       empty;
      bit       afull;
      bit       aempty;
      bit [7:0] data;
      bit [7:0] fdata;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic chk_st(input string tag, input int cnt,
                         input bit e_full, input bit e_empty,
                         input bit e_afull, input bit e_aempty);
      chk({tag, ".count"},  32'(count),  32'(cnt));
      chk({tag, ".full"},   32'(full),   32'(e_full));
      chk({tag, ".empty"},  32'(empty),  32'(e_empty));
      chk({tag, ".afull"},  32'(afull),  32'(e_afull));
      chk({tag, ".aempty"}, 32'(aempty), 32'(e_aempty));
      chk({tag, ".count_f"}, 32'(count_f), 32'(cnt));
   endtask

   task automatic cyc(input bit w, input bit r, input bit f,
                      input logic [7:0] d);
      wr    = w;
      rd    = r;
      flush = f;
      din   = d;
      @(posedge clk);
      #1;
      wr    = 1'b0;
      rd    = 1'b0;
      flush = 1'b0;
   endtask

   function automatic vec_t mk(bit w, bit r, bit f, bit [7:0] d, int c,
                               bit fu, bit em, bit af, bit ae,
                               bit [7:0] q, bit [7:0] fq);
      vec_t v;
      v.wr = w; v.rd = r; v.fl = f; v.din = d; v.cnt = c;
      v.full = fu; v.empty = em; v.afull = af; v.aempty = ae;
      v.data = q; v.fdata = fq;
      return v;
   endfunction

   initial begin
      tbl[0]  = mk(1, 0, 0, 8'h11, 1, 0, 0, 0, 1, 8'h00, 8'h11);
      tbl[1]  = mk(1, 0, 0, 8'h22, 2, 0, 0, 0, 1, 8'h00, 8'h11);
      tbl[2]  = mk(1, 0, 0, 8'h33, 3, 0, 0, 0, 0, 8'h00, 8'h11);
      tbl[3]  = mk(0, 1, 0, 8'h00, 2, 0, 0, 0, 1, 8'h11, 8'h22);
      tbl[4]  = mk(0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h22, 8'h33);
      tbl[5]  = mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 8'h33, 8'h00);
      tbl[6]  = mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 8'h33, 8'h00);
      tbl[7]  = mk(1, 0, 0, 8'h01, 1, 0, 0, 0, 1, 8'h33, 8'h01);
      tbl[8]  = mk(1, 0, 0, 8'h02, 2, 0, 0, 0, 1, 8'h33, 8'h01);
      tbl[9]  = mk(1, 0, 0, 8'h03, 3, 0, 0, 0, 0, 8'h33, 8'h01);
      tbl[10] = mk(1, 0, 0, 8'h04, 4, 0, 0, 0, 0, 8'h33, 8'h01);
      tbl[11] = mk(1, 0, 0, 8'h05, 5, 0, 0, 0, 0, 8'h33, 8'h01);
      tbl[12] = mk(1, 1, 1, 8'hAA, 0, 0, 1, 0, 1, 8'h33, 8'h00);
      tbl[13] = mk(1, 1, 0, 8'h44, 1, 0, 0, 0, 1, 8'h33, 8'h44);
      tbl[14] = mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 8'h44, 8'h00);

      rst_n = 1'b0;
      wr = 1'b0; rd = 1'b0; flush = 1'b0; din = 8'h00;
      #12;
      chk_st("reset", 0, 0, 1, 0, 1);
      chk("reset.data", 32'(dout), 32'h0);
`ifdef SYN_FIFO_FLEX_ERR_EN
      chk("reset.ovf", 32'(ovf), 32'h0);
      chk("reset.udf", 32'(udf), 32'h0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic order, underflow attempt, flush, read-on-empty with write.
      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].din);
         chk_st($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].full,
                tbl[i].empty, tbl[i].afull, tbl[i].aempty);
         chk($sformatf("vec%0d.data", i), 32'(dout), 32'(tbl[i].data));
         if (tbl[i].cnt != 0)
            chk($sformatf("vec%0d.fdata", i), 32'(dout_f),
                32'(tbl[i].fdata));
`ifdef SYN_FIFO_FLEX_ERR_EN
         if (i == 6) chk("vec6.udf", 32'(udf), 32'h1);
         if (i == 12) chk("vec12.udf", 32'(udf), 32'h0);
`endif
      end

      // Fill to full, then overflow attempt.
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, 0, 8'h80 + 8'(i));
         chk_st($sformatf("fill%0d", i), i + 1, (i + 1) == 16, 0,
                (i + 1) >= 12, (i + 1) <= 2);
      end
      chk("fill.fdata", 32'(dout_f), 32'h80);
`ifdef SYN_FIFO_FLEX_ERR_EN
      chk("fill.ovf", 32'(ovf), 32'h0);
`endif
      cyc(1, 0, 0, 8'hEE);
      chk_st("ovf", 16, 1, 0, 1, 0);
`ifdef SYN_FIFO_FLEX_ERR_EN
      chk("ovf.ovf", 32'(ovf), 32'h1);
`endif

      // Full: read wins, write refused.
      cyc(1, 1, 0, 8'hDD);
      chk_st("fullrw", 15, 0, 0, 1, 0);
      chk("fullrw.data", 32'(dout), 32'h80);
      chk("fullrw.fdata", 32'(dout_f), 32'h81);
      for (int i = 0; i < 7; i++) cyc(0, 1, 0, 8'h00);
      chk_st("cnt8", 8, 0, 0, 0, 0);
      chk("cnt8.data", 32'(dout), 32'h87);
      cyc(1, 1, 0, 8'hC0);
      chk_st("rw8", 8, 0, 0, 0, 0);
      chk("rw8.data", 32'(dout), 32'h88);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 0, 8'h00);
         chk($sformatf("drain%0d.data", i), 32'(dout),
             (i == 7) ? 32'hC0 : 32'(8'h89 + 8'(i)));
      end
      chk_st("drained", 0, 0, 1, 0, 1);
`ifdef SYN_FIFO_FLEX_ERR_EN
      cyc(0, 1, 0, 8'h00);
      chk("udf2.udf", 32'(udf), 32'h1);
      chk("udf2.ovf", 32'(ovf), 32'h1);
      cyc(0, 0, 1, 8'h00);
      chk("flush2.ovf", 32'(ovf), 32'h0);
      chk("flush2.udf", 32'(udf), 32'h0);
`endif

      // Steady-state streaming across pointer wrap.
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'(i));
      for (int i = 0; i < 40; i++) begin
         cyc(1, 1, 0, 8'(i + 3));
         chk($sformatf("wrap%0d.count", i), 32'(count), 32'd3);
         chk($sformatf("wrap%0d.data", i), 32'(dout), 32'(i));
         chk($sformatf("wrap%0d.fdata", i), 32'(dout_f), 32'(i + 1));
      end

      // Asynchronous reset between edges.
      wr = 1'b1;
      din = 8'h77;
      #2;
      rst_n = 1'b0;
      #1;
      chk_st("areset", 0, 0, 1, 0, 1);
      chk("areset.data", 32'(dout), 32'h0);
      wr = 1'b0;
      #2;
      rst_n = 1'b1;
      cyc(1, 0, 0, 8'h5A);
      chk_st("post", 1, 0, 0, 0, 1);
      chk("post.fdata", 32'(dout_f), 32'h5A);
      cyc(0, 1, 0, 8'h00);
      chk("post.data", 32'(dout), 32'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/syn_fifo_flex.md
Name: syn_fifo_flex

Overview:
Parametrised synchronous FIFO, the next generation of the team's single-clock FIFO. Adds:
- a selectable read mode: registered read, or first-word-fall-through (FWFT);
- an occupancy count;
- programmable almost-full and almost-empty flags;
- a synchronous flush.

It sits between single-clock producer/consumer stages that need back-pressure margin before hard full/empty.

Parameters:
P_DATA_W, 8, data word width in bits (>=1)
P_DEPTH, 16, number of entries; power of 2, >=2
P_AFULL_TH, 12, o_afull asserted when count >= this value (1..P_DEPTH)
P_AEMPTY_TH, 2, o_aempty asserted when count <= this value (0..P_DEPTH-1)
P_FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
i_flush  input  1  synchronous flush; empties FIFO
i_data  input  P_DATA_W  write data
i_wr_en  input  1  write request
i_rd_en  input  1  read request (pop)
o_full  output  1  count == P_DEPTH
o_empty  output  1  count == 0
o_afull  output  1  count >= P_AFULL_TH
o_aempty  output  1  count <= P_AEMPTY_TH
o_count  output  $clog2(P_DEPTH)+1  current occupancy, 0..P_DEPTH
o_data  output  P_DATA_W  read data

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous, active-low; assertion clears state immediately, regardless of clk.
  - Pointers = 0, o_count = 0, o_empty = 1, o_full = 0, o_aempty = 1, o_afull = 0, o_data = 0, error flags = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words.
- Pointers: wr_ptr/rd_ptr are $clog2(P_DEPTH)+1 bits; the low bits index memory and the MSB is the wrap bit.
  - Increments wrap naturally modulo 2*P_DEPTH.
  - o_count = wr_ptr - rd_ptr, truncated to pointer width.
  - All flags are decoded combinationally from the registered pointers.
- Write: accepted when i_wr_en && !o_full. Stores i_data at wr_ptr and increments wr_ptr.
- Read: accepted when i_rd_en && !o_empty. Increments rd_ptr.
- Flag sampling: both accept decisions use the pre-edge flags.
  - Simultaneous accepted read and write: count unchanged.
  - When full: a write is refused even if a read is accepted in the same cycle.
  - When empty: a read is refused even if a write is accepted in the same cycle.
- P_FWFT = 0 (registered read):
  - On an accepted read, o_data <= mem[rd_ptr] at the edge, so data is valid the cycle after the request.
  - o_data holds its value otherwise, including across a flush.
- P_FWFT = 1 (first-word-fall-through):
  - o_data = mem[rd_ptr] combinationally and is valid whenever o_empty = 0.
  - A word written at edge N is visible after edge N.
  - An accepted read advances to the next word.
  - When o_empty = 1, o_data is don't-care; the bench must not check it.
- Flush: i_flush = 1 sets wr_ptr = rd_ptr = 0 at the next edge.
  - Overrides i_wr_en/i_rd_en in the same cycle; neither is accepted.
- Threshold checks: P_AFULL_TH and P_AEMPTY_TH out of range -> elaboration error via generate-time check.

Optional Feature:
Macro SYN_FIFO_FLEX_ERR_EN.
- When defined, adds two outputs:
  - o_ovf (1 bit): sticky; sets when i_wr_en && o_full.
  - o_udf (1 bit): sticky; sets when i_rd_en && o_empty.
- Both cleared only by rst_n or i_flush; flush has priority over set in the same cycle.
- Not defined: ports absent; refused requests are silently dropped.

Decomposition:
- Package syn_fifo_pkg holds:
  - the pointer-width function: clog2(depth)+1;
  - read-mode constants FIFO_MODE_REG = 0 and FIFO_MODE_FWFT = 1;
  - a shared threshold-check function.
- One sub-module, syn_fifo_mem: P_DEPTH x P_DATA_W register array.
  - Single synchronous write port.
  - Asynchronous read port.
  - The top adds the output register when P_FWFT = 0.

Test Plan:
1. P_FWFT=0, write 0x11,0x22,0x33, then read x3 -> o_data = 0x11,0x22,0x33, each one cycle after its rd_en; o_count 3->0; o_empty = 1 after the last read.
2. Depth 16, write 16 words -> o_afull at count 12, o_full at 16; a 17th write is dropped and o_count stays 16; with SYN_FIFO_FLEX_ERR_EN, o_ovf = 1.
3. Full FIFO, rd_en and wr_en together -> read accepted, write refused, count 15. Count 8, rd_en and wr_en together -> count stays 8 and data order is preserved.
4. P_FWFT=1, write 0xA5 at edge N -> o_data = 0xA5 and o_empty = 0 after edge N without a read; a read pops and o_empty = 1.
5. Count 5, i_flush with wr_en and rd_en high -> count 0, o_empty = 1, o_aempty = 1, o_data held (mode 0), o_ovf/o_udf cleared.
6. Wrap: 40 interleaved write/read pairs with incrementing data -> in-order output, correct o_count across pointer-MSB wrap. Assert rst_n low asynchronously mid-sequence -> all outputs take reset values before the next clk edge.
